// File: rtl/memlog_reader.sv
// memlog_reader: walks the sample logger's memory after it fills and streams each
// 16-bit I/Q word as two bytes, I (MSB) first. Optional re-arm: MEMLOG_RD_REARM_EN.
module memlog_reader #(
  parameter int                         BRAM_ADDR_WIDTH = 15,
  parameter int                         BRAM_DATA_WIDTH = 16,
  parameter logic [BRAM_ADDR_WIDTH-1:0] LAST_ADDR       = {BRAM_ADDR_WIDTH{1'b1}},
  parameter int                         RD_LATENCY      = 2
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_mem_full,
  input  logic [BRAM_DATA_WIDTH-1:0] i_data_log,
  input  logic                       i_tx_ready,
  output logic                       o_read_log,
  output logic                       o_run_log,
  output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log,
  output logic [7:0]                 o_tx_data,
  output logic                       o_tx_valid,
  output logic                       o_busy,
  output logic                       o_done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_FULL = 3'd1,
    S_REQ       = 3'd2,
    S_SETTLE    = 3'd3,
    S_WAIT_DATA = 3'd4,
    S_SEND_HI   = 3'd5,
    S_SEND_LO   = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  localparam logic [2:0]                 LAT_LOAD = 3'(RD_LATENCY - 1);
  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE = BRAM_ADDR_WIDTH'(1);

`ifdef MEMLOG_RD_REARM_EN
  localparam logic REARM = 1'b1;
`else
  localparam logic REARM = 1'b0;
`endif

  state_t                       state_q;
  logic [BRAM_ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]                   cnt_q;
  logic [BRAM_DATA_WIDTH-1:0]   word_q;
  logic [7:0]                   tx_data_q;
  logic                         tx_valid_q;
  logic                         read_log_q;
  logic                         run_log_q;
  logic                         done_q;
  logic                         busy_q;

  // Dump sequencer; SETTLE doubles as the first latency cycle so capture lands
  // exactly RD_LATENCY edges after the address is presented.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= 3'd0;
      word_q     <= '0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      read_log_q <= 1'b0;
      run_log_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      read_log_q <= 1'b0;
      run_log_q  <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q <= S_WAIT_FULL;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        S_WAIT_FULL: begin
          if (i_mem_full) begin
            state_q    <= S_REQ;
            read_log_q <= 1'b1;
          end
        end
        S_REQ: begin
          state_q <= S_SETTLE;
          addr_q  <= '0;
          cnt_q   <= LAT_LOAD;
        end
        S_SETTLE, S_WAIT_DATA: begin
          if (cnt_q == 3'd0) begin
            word_q     <= i_data_log;
            tx_data_q  <= i_data_log[15:8];
            tx_valid_q <= 1'b1;
            state_q    <= S_SEND_HI;
          end else begin
            cnt_q   <= cnt_q - 3'd1;
            state_q <= S_WAIT_DATA;
          end
        end
        S_SEND_HI: begin
          if (i_tx_ready) begin
            tx_data_q <= word_q[7:0];
            state_q   <= S_SEND_LO;
          end
        end
        S_SEND_LO: begin
          if (i_tx_ready) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'd0;
            // The LAST_ADDR compare ends the walk, so the address never wraps.
            if (addr_q == LAST_ADDR) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              run_log_q <= REARM;
            end else begin
              addr_q  <= addr_q + ADDR_ONE;
              cnt_q   <= LAT_LOAD;
              state_q <= S_SETTLE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          addr_q  <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign o_read_log = read_log_q;
  assign o_run_log  = run_log_q;
  assign o_addr_log = addr_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_memlog_reader.sv
// Self-checking bench for memlog_reader: two instances (latency 2 / latency 3) fed by
// a memory model whose data is correct only in the exact latency cycle.
module tb_memlog_reader;
  localparam int LAT_A = 2;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0, start_a = 1'b0, start_b = 1'b0, mem_full = 1'b0, tx_ready = 1'b0;
  logic [15:0] data_a, data_b;
  logic [14:0] addr_a;
  logic [2:0]  addr_b;
  logic [7:0]  txd_a, txd_b;
  logic txv_a, txv_b, rl_a, rl_b, run_a, run_b, done_a, done_b, busy_a, busy_b;

  always #5 clk = ~clk;

  memlog_reader #(.BRAM_ADDR_WIDTH(15), .BRAM_DATA_WIDTH(16), .LAST_ADDR(15'd3),
                  .RD_LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_mem_full(mem_full),
    .i_data_log(data_a), .i_tx_ready(tx_ready), .o_read_log(rl_a), .o_run_log(run_a),
    .o_addr_log(addr_a), .o_tx_data(txd_a), .o_tx_valid(txv_a), .o_busy(busy_a),
    .o_done(done_a));

  memlog_reader #(.BRAM_ADDR_WIDTH(3), .BRAM_DATA_WIDTH(16), .RD_LATENCY(LAT_B)) u_dut_b (
    .clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_mem_full(mem_full),
    .i_data_log(data_b), .i_tx_ready(tx_ready), .o_read_log(rl_b), .o_run_log(run_b),
    .o_addr_log(addr_b), .o_tx_data(txd_b), .o_tx_valid(txv_b), .o_busy(busy_b),
    .o_done(done_b));

  // Memory model: data is mem[addr] only in the cycle exactly LAT-1 cycles after the
  // address was (re)presented, inverted garbage otherwise.
  logic [15:0] mem_a [4];
  logic [15:0] mem_b [8];
  logic [14:0] last_addr_a = 15'd0;
  logic [2:0]  last_addr_b = 3'd0;
  logic        last_rl_a = 1'b0, last_rl_b = 1'b0;
  int          age_a = 0, age_b = 0;
  logic        ev_a, ev_b;

  always_comb begin
    ev_a = (addr_a != last_addr_a) || (last_rl_a && !rl_a);
    ev_b = (addr_b != last_addr_b) || (last_rl_b && !rl_b);
    data_a = ((ev_a ? 0 : age_a) == LAT_A - 1) ? mem_a[addr_a[1:0]] : ~mem_a[addr_a[1:0]];
    data_b = ((ev_b ? 0 : age_b) == LAT_B - 1) ? mem_b[addr_b] : ~mem_b[addr_b];
  end

  always @(posedge clk) begin
    last_addr_a <= addr_a;
    last_addr_b <= addr_b;
    last_rl_a   <= rl_a;
    last_rl_b   <= rl_b;
    age_a       <= ev_a ? 1 : ((age_a < 100) ? age_a + 1 : age_a);
    age_b       <= ev_b ? 1 : ((age_b < 100) ? age_b + 1 : age_b);
  end

  // Monitor of the selected instance
  logic       sel = 1'b0;
  logic       m_valid, m_rl, m_run, m_done, m_busy;
  logic [7:0] m_data;
  assign m_valid = sel ? txv_b  : txv_a;
  assign m_data  = sel ? txd_b  : txd_a;
  assign m_rl    = sel ? rl_b   : rl_a;
  assign m_run   = sel ? run_b  : run_a;
  assign m_done  = sel ? done_b : done_a;
  assign m_busy  = sel ? busy_b : busy_a;

  int n_checks = 0, n_fail = 0;
  int n_rl = 0, n_done = 0, n_run = 0, n_both = 0, stab_err = 0;
  int rl_cyc = 0, done_cyc = 0, start_cyc = 0, cyc = 0;
  logic       hold_q = 1'b0;
  logic [7:0] hold_d = 8'd0;
  logic [7:0] got_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (hold_q && !(m_valid && m_data == hold_d)) stab_err++;
    hold_q = m_valid && !tx_ready;
    hold_d = m_data;
    if (m_valid && tx_ready) got_q.push_back(m_data);
    if (m_rl) begin n_rl++; rl_cyc = cyc; end
    if (m_done) begin n_done++; done_cyc = cyc; end
    if (m_run) n_run++;
    if (m_run && m_done) n_both++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    n_rl = 0; n_done = 0; n_run = 0; n_both = 0; stab_err = 0;
    hold_q = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 4; i++) mem_a[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) mem_b[i] = 16'($urandom);
  endtask

  task automatic pulse_start();
    tick();
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    start_cyc = cyc;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // mode 0: ready high, 1: pattern 0,0,1, 2: random
  task automatic run_dump(input int mode, input int limit, input string tag);
    int phase = 0;
    bit fin = 1'b0;
    for (int i = 0; i < limit && !fin; i++) begin
      case (mode)
        0: tx_ready = 1'b1;
        1: begin tx_ready = (phase == 2); phase = (phase + 1) % 3; end
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      if (n_done > 0 && !m_busy) fin = 1'b1;
    end
    tx_ready = 1'b1;
    n_checks++;
    if (!fin) begin n_fail++; $display("FAIL %s_timeout: finished=%0b expected=1", tag, fin); end
  endtask

  task automatic check_stream(input string tag);
    logic [7:0] exp_q [$];
    if (sel) begin
      for (int a = 0; a < 8; a++) begin exp_q.push_back(mem_b[a][15:8]); exp_q.push_back(mem_b[a][7:0]); end
    end else begin
      for (int a = 0; a < 4; a++) begin exp_q.push_back(mem_a[a][15:8]); exp_q.push_back(mem_a[a][7:0]); end
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL %s_count: got %0d bytes expected %0d", tag, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL %s_byte%0d: got %h expected %h", tag, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    bit seen = 1'b0;
    bit busy_seen = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({txd_a, txv_a, rl_a, run_a, addr_a, done_a, busy_a, txd_b, txv_b, rl_b, run_b, addr_b, done_b, busy_b} !== '0) begin
      n_fail++; $display("FAIL reset_init: outputs a=%h/%b b=%h/%b expected all 0", txd_a, busy_a, txd_b, busy_b);
    end
    rst_n = 1'b1;
    sel = 1'b0; fill_random(); mem_full = 1'b1; tx_ready = 1'b0; clear_mon();
    pulse_start();
    for (int i = 0; i < 40 && !seen; i++) begin tick(); if (m_valid) seen = 1'b1; end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL reset_reach_send: valid=%b expected 1", seen); end
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({txd_a, txv_a, rl_a, run_a, addr_a, done_a, busy_a} !== '0) begin
        n_fail++; $display("FAIL reset_mid_dump%0d: data=%h valid=%b addr=%h busy=%b expected 0", i, txd_a, txv_a, addr_a, busy_a);
      end
    end
    rst_n = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin @(posedge clk); @(negedge clk); if (m_busy || m_valid) busy_seen = 1'b1; end
    n_checks++;
    if (busy_seen) begin n_fail++; $display("FAIL reset_idle_after: busy/valid seen=%b expected 0", busy_seen); end
  endtask

  task automatic test_basic();
    sel = 1'b0;
    mem_a[0] = 16'h1234; mem_a[1] = 16'h5678; mem_a[2] = 16'h9ABC; mem_a[3] = 16'hDEF0;
    mem_full = 1'b1; tx_ready = 1'b1; clear_mon();
    pulse_start();
    run_dump(0, 200, "basic");
    check_stream("basic");
    n_checks++;
    if (n_rl != 1) begin n_fail++; $display("FAIL basic_read_log: pulses=%0d expected 1", n_rl); end
    n_checks++;
    if (n_done != 1) begin n_fail++; $display("FAIL basic_done: high cycles=%0d expected 1", n_done); end
    n_checks++;
    if (rl_cyc - start_cyc != 2) begin n_fail++; $display("FAIL basic_start_to_req: got %0d expected 2", rl_cyc - start_cyc); end
    n_checks++;
    if (done_cyc - rl_cyc != 1 + 4 * (LAT_A + 2)) begin
      n_fail++; $display("FAIL basic_dump_cycles: got %0d expected %0d", done_cyc - rl_cyc, 1 + 4 * (LAT_A + 2));
    end
    n_checks++;
    if (addr_a !== 15'd0 || m_busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_end_state: addr=%h busy=%b expected 0/0", addr_a, m_busy);
    end
  endtask

  task automatic test_gating();
    bit busy_low = 1'b0;
    sel = 1'b0; fill_random(); mem_full = 1'b0; tx_ready = 1'b1; clear_mon();
    pulse_start();
    for (int i = 0; i < 50; i++) begin tick(); if (!m_busy) busy_low = 1'b1; end
    n_checks++;
    if (n_rl != 0) begin n_fail++; $display("FAIL gating_read_log: pulses=%0d expected 0", n_rl); end
    n_checks++;
    if (busy_low) begin n_fail++; $display("FAIL gating_busy: busy dropped=%b expected 0", busy_low); end
    mem_full = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (m_rl !== 1'b1) begin n_fail++; $display("FAIL gating_req_next_cycle: read_log=%b expected 1", m_rl); end
    run_dump(0, 200, "gating");
    check_stream("gating");
  endtask

  task automatic test_backpressure();
    sel = 1'b0; fill_random(); mem_full = 1'b1; tx_ready = 1'b1; clear_mon();
    pulse_start();
    repeat (3) tick();
    mem_full = 1'b0;
    run_dump(1, 400, "backpressure");
    check_stream("backpressure");
    n_checks++;
    if (stab_err != 0) begin n_fail++; $display("FAIL backpressure_stable: violations=%0d expected 0", stab_err); end
    n_checks++;
    if (n_done != 1) begin n_fail++; $display("FAIL backpressure_done: high cycles=%0d expected 1", n_done); end
  endtask

  task automatic test_latency();
    sel = 1'b1; fill_random(); mem_full = 1'b1; tx_ready = 1'b1; clear_mon();
    pulse_start();
    run_dump(0, 400, "latency");
    check_stream("latency");
    n_checks++;
    if (done_cyc - rl_cyc != 1 + 8 * (LAT_B + 2)) begin
      n_fail++; $display("FAIL latency_dump_cycles: got %0d expected %0d", done_cyc - rl_cyc, 1 + 8 * (LAT_B + 2));
    end
    n_checks++;
    if (addr_b !== 3'd0) begin n_fail++; $display("FAIL latency_addr_clear: addr=%h expected 0", addr_b); end
  endtask

  task automatic test_back_to_back();
    sel = 1'b1; fill_random(); mem_full = 1'b1; tx_ready = 1'b1; clear_mon();
    pulse_start();
    run_dump(2, 800, "random_ready");
    check_stream("random_ready");
    n_checks++;
    if (stab_err != 0) begin n_fail++; $display("FAIL random_ready_stable: violations=%0d expected 0", stab_err); end
    n_checks++;
    if (n_done != 1 || n_rl != 1) begin
      n_fail++; $display("FAIL random_ready_pulses: done=%0d read_log=%0d expected 1/1", n_done, n_rl);
    end
  endtask

  task automatic test_rearm();
    sel = 1'b0; fill_random(); mem_full = 1'b1; tx_ready = 1'b1; clear_mon();
    pulse_start();
    run_dump(0, 200, "rearm");
`ifdef MEMLOG_RD_REARM_EN
    n_checks++;
    if (n_run != 1 || n_both != 1) begin
      n_fail++; $display("FAIL rearm_pulse: run_log cycles=%0d with_done=%0d expected 1/1", n_run, n_both);
    end
`else
    n_checks++;
    if (n_run != 0) begin n_fail++; $display("FAIL rearm_tied_low: run_log cycles=%0d expected 0", n_run); end
`endif
    n_checks++;
    if (n_done != 1) begin n_fail++; $display("FAIL rearm_done: high cycles=%0d expected 1", n_done); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_basic();
    test_gating();
    test_backpressure();
    test_latency();
    test_back_to_back();
    test_rearm();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
